// File: rtl/mac_array_seq_pkg.sv
// mac_array_seq_pkg: shared states, instruction codes and drain length
package mac_array_seq_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, EXEC, DRAIN, FIN} state_t;
  localparam logic [1:0] INST_IDLE = 2'b00;
  localparam logic [1:0] INST_LOAD = 2'b01;
  localparam logic [1:0] INST_EXEC = 2'b10;
  function automatic int drain_len(input int row, input int col);
    return 1 + row + col;
  endfunction
endpackage

// File: rtl/mac_array_seq_if.sv
// mac_array_seq_if: controller/datapath bus of the tile sequencer
interface mac_array_seq_if #(parameter int len_bw = 8, parameter int addr_bw = 11);
  logic start;
  logic [len_bw-1:0] exec_len;
  logic [addr_bw-1:0] w_base;
  logic [addr_bw-1:0] x_base;
  logic mode_cfg;
  logic ofifo_full;
  logic sram_cen;
  logic [addr_bw-1:0] sram_addr;
  logic [1:0] inst_w;
  logic mode;
  logic busy;
  logic done;
  modport master (output start, exec_len, w_base, x_base, mode_cfg, ofifo_full,
                  input sram_cen, sram_addr, inst_w, mode, busy, done);
  modport slave (input start, exec_len, w_base, x_base, mode_cfg, ofifo_full,
                 output sram_cen, sram_addr, inst_w, mode, busy, done);
endinterface

// File: rtl/mac_array_seq_counter.sv
// seq_counter: loadable up-counter with enable and terminal-count flag
module seq_counter #(parameter int bw = 8) (
  input logic clk,
  input logic reset,
  input logic ld,
  input logic [bw-1:0] d,
  input logic en,
  input logic [bw-1:0] last,
  output logic [bw-1:0] q,
  output logic tc
);
  always_ff @(posedge clk)
    q <= reset ? '0 : ld ? d : en ? q + bw'(1) : q;
  assign tc = q == last;
endmodule

// File: rtl/mac_array_seq.sv
// mac_array_seq: sequences kernel load, execute and drain of one array tile
module mac_array_seq
  import mac_array_seq_pkg::*;
#(
  parameter int row = 4,
  parameter int col = 4,
  parameter int len_bw = 8,
  parameter int addr_bw = 11
) (
  input logic clk,
  input logic reset,
  mac_array_seq_if.slave bus
);
  localparam int dl = drain_len(row, col);
  state_t state, state_n;
  logic [len_bw-1:0] len_q, idx, idx_last, drn_unused;
  logic [addr_bw-1:0] w_q, x_q;
  logic [1:0] kind, inst_q;
  logic mode_q, idx_ld, idx_tc, drn_tc;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      inst_q <= INST_IDLE;
      len_q <= '0;
      w_q <= '0;
      x_q <= '0;
      mode_q <= 1'b0;
    end else begin
      state <= state_n;
      inst_q <= kind;
      if (state == IDLE && bus.start) begin
        len_q <= bus.exec_len;
        w_q <= bus.w_base;
        x_q <= bus.x_base;
        mode_q <= bus.mode_cfg;
      end
    end
  end
  always_comb begin
    state_n = state;
    kind = INST_IDLE;
    case (state)
      IDLE: state_n = bus.start ? LOAD : IDLE;
      LOAD: begin
        kind = INST_LOAD;
        state_n = idx_tc ? (len_q == '0 ? DRAIN : EXEC) : LOAD;
      end
      EXEC: begin
        kind = bus.ofifo_full ? INST_IDLE : INST_EXEC;
        state_n = (!bus.ofifo_full && idx_tc) ? DRAIN : EXEC;
      end
      DRAIN: state_n = drn_tc ? FIN : DRAIN;
      default: state_n = IDLE;
    endcase
  end
  assign idx_ld = state == IDLE || (state == LOAD && idx_tc);
  assign idx_last = state == LOAD ? len_bw'(row - 1) : len_q - len_bw'(1);
  seq_counter #(.bw(len_bw)) u_idx (
    .clk(clk), .reset(reset), .ld(idx_ld), .d('0), .en(kind != INST_IDLE),
    .last(idx_last), .q(idx), .tc(idx_tc)
  );
  seq_counter #(.bw(len_bw)) u_drn (
    .clk(clk), .reset(reset), .ld(state != DRAIN), .d('0), .en(1'b1),
    .last(len_bw'(dl - 1)), .q(drn_unused), .tc(drn_tc)
  );
  assign bus.sram_cen = kind == INST_IDLE;
  assign bus.sram_addr = state == LOAD ? w_q + addr_bw'(idx) :
                         state == EXEC ? x_q + addr_bw'(idx) : '0;
  assign bus.inst_w = inst_q;
  assign bus.mode = mode_q;
  assign bus.busy = state == LOAD || state == EXEC || state == DRAIN;
  assign bus.done = state == FIN;
endmodule

// File: tb/tb_mac_array_seq.sv
// tb_mac_array_seq: randomized self-checking bench for the tile sequencer
module tb_mac_array_seq;
  localparam int row = 4, col = 4, len_bw = 8, addr_bw = 11;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0, errors = 0;
  logic fp [0:255];
  logic e_cen[$];
  logic [addr_bw-1:0] e_addr[$];
  logic [1:0] e_inst[$];
  logic e_busy[$];
  logic e_done[$];
  mac_array_seq_if #(.len_bw(len_bw), .addr_bw(addr_bw)) bus ();
  mac_array_seq #(.row(row), .col(col), .len_bw(len_bw), .addr_bw(addr_bw)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic clear_fp();
    for (int i = 0; i < 256; i++) fp[i] = 1'b0;
  endtask
  task automatic push(input logic c, input logic [addr_bw-1:0] a, input logic [1:0] in,
                      input logic b, input logic d);
    e_cen.push_back(c);
    e_addr.push_back(a);
    e_inst.push_back(in);
    e_busy.push_back(b);
    e_done.push_back(d);
  endtask
  task automatic build(input int len, input logic [addr_bw-1:0] wb, input logic [addr_bw-1:0] xb);
    logic [1:0] prev;
    int j;
    e_cen.delete(); e_addr.delete(); e_inst.delete(); e_busy.delete(); e_done.delete();
    prev = 2'b00;
    for (int k = 0; k < row; k++) begin
      push(1'b0, wb + addr_bw'(k), prev, 1'b1, 1'b0);
      prev = 2'b01;
    end
    j = 0;
    while (j < len) begin
      if (fp[e_cen.size()]) begin
        push(1'b1, xb + addr_bw'(j), prev, 1'b1, 1'b0);
        prev = 2'b00;
      end else begin
        push(1'b0, xb + addr_bw'(j), prev, 1'b1, 1'b0);
        prev = 2'b10;
        j++;
      end
    end
    for (int d = 0; d < 1 + row + col; d++) begin
      push(1'b1, 'x, prev, 1'b1, 1'b0);
      prev = 2'b00;
    end
    push(1'b1, 'x, 2'b00, 1'b0, 1'b1);
  endtask
  task automatic run_tile(input int len, input logic [addr_bw-1:0] wb, input logic [addr_bw-1:0] xb,
                          input logic md, input int s1, input int s2, input int abort_at,
                          output int done_t);
    build(len, wb, xb);
    done_t = -1;
    @(negedge clk);
    bus.start = 1'b1;
    bus.exec_len = len_bw'(len);
    bus.w_base = wb;
    bus.x_base = xb;
    bus.mode_cfg = md;
    bus.ofifo_full = 1'b0;
    for (int i = 0; i < e_cen.size(); i++) begin
      @(negedge clk);
      bus.start = (i == s1 || i == s2);
      if (bus.start) begin
        bus.exec_len = 8'd50;
        bus.w_base = 11'h555;
        bus.x_base = 11'h2AA;
        bus.mode_cfg = ~md;
      end
      bus.ofifo_full = fp[i];
      if (i == abort_at) begin
        reset = 1'b1;
        break;
      end
      #1;
      if (bus.done === 1'b1 && done_t < 0) done_t = i + 1;
      checks++;
      if (bus.sram_cen !== e_cen[i]) begin
        errors++;
        $display("FAIL cen t=%0d got %b exp %b", i + 1, bus.sram_cen, e_cen[i]);
      end
      if (!$isunknown(e_addr[i])) begin
        checks++;
        if (bus.sram_addr !== e_addr[i]) begin
          errors++;
          $display("FAIL addr t=%0d got %h exp %h", i + 1, bus.sram_addr, e_addr[i]);
        end
      end
      checks++;
      if (bus.inst_w !== e_inst[i]) begin
        errors++;
        $display("FAIL inst_w t=%0d got %b exp %b", i + 1, bus.inst_w, e_inst[i]);
      end
      checks++;
      if (bus.busy !== e_busy[i]) begin
        errors++;
        $display("FAIL busy t=%0d got %b exp %b", i + 1, bus.busy, e_busy[i]);
      end
      checks++;
      if (bus.done !== e_done[i]) begin
        errors++;
        $display("FAIL done t=%0d got %b exp %b", i + 1, bus.done, e_done[i]);
      end
      checks++;
      if (bus.mode !== md) begin
        errors++;
        $display("FAIL mode t=%0d got %b exp %b", i + 1, bus.mode, md);
      end
    end
    bus.start = 1'b0;
    bus.ofifo_full = 1'b0;
  endtask
  task automatic check_reset_vals(input string tag);
    checks++;
    if (bus.sram_cen !== 1'b1 || bus.sram_addr !== '0 || bus.inst_w !== 2'b00 ||
        bus.mode !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL %s got cen=%b addr=%h inst=%b mode=%b busy=%b done=%b exp 1/000/00/0/0/0",
               tag, bus.sram_cen, bus.sram_addr, bus.inst_w, bus.mode, bus.busy, bus.done);
    end
  endtask
  task automatic check_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.ofifo_full = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.sram_cen !== 1'b1 || bus.inst_w !== 2'b00) begin
        errors++;
        $display("FAIL idle c=%0d got busy=%b done=%b cen=%b inst=%b exp 0/0/1/00",
                 i, bus.busy, bus.done, bus.sram_cen, bus.inst_w);
      end
    end
    bus.ofifo_full = 1'b0;
  endtask
  task automatic check_done_t(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s done cycle got %0d exp %0d", tag, got, exp);
    end
  endtask
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_reset_vals("reset");
    reset = 1'b0;
  endtask
  task automatic test_basic();
    int dt;
    clear_fp();
    run_tile(3, 11'h010, 11'h100, 1'b0, -1, -1, -1, dt);
    check_done_t("basic", dt, 17);
  endtask
  task automatic test_backpressure();
    int dt;
    clear_fp();
    fp[5] = 1'b1;
    fp[6] = 1'b1;
    run_tile(3, 11'h010, 11'h100, 1'b1, -1, -1, -1, dt);
    check_done_t("backpressure", dt, 19);
  endtask
  task automatic test_zero_len();
    int dt;
    clear_fp();
    fp[1] = 1'b1;
    fp[6] = 1'b1;
    run_tile(0, 11'h020, 11'h300, 1'b0, -1, -1, -1, dt);
    check_done_t("zero_len", dt, 14);
  endtask
  task automatic test_reset_mid();
    int dt;
    clear_fp();
    run_tile(5, 11'h040, 11'h200, 1'b1, -1, -1, row + 1, dt);
    @(negedge clk);
    #1;
    check_reset_vals("reset_mid");
    reset = 1'b0;
    check_idle(20);
    run_tile(5, 11'h040, 11'h200, 1'b1, -1, -1, -1, dt);
    check_done_t("after_reset", dt, 19);
  endtask
  task automatic test_start_busy();
    int dt;
    clear_fp();
    run_tile(3, 11'h010, 11'h100, 1'b1, 1, 16, -1, dt);
    check_done_t("start_busy", dt, 17);
    check_idle(12);
  endtask
  task automatic test_back_to_back();
    int dt;
    clear_fp();
    run_tile(2, 11'h0A0, 11'h0B0, 1'b1, -1, -1, -1, dt);
    check_done_t("b2b_0", dt, 16);
    run_tile(4, 11'h0C0, 11'h0D0, 1'b0, -1, -1, -1, dt);
    check_done_t("b2b_1", dt, 18);
    run_tile(1, 11'h0E0, 11'h0F0, 1'b1, -1, -1, -1, dt);
    check_done_t("b2b_2", dt, 15);
  endtask
  task automatic test_wrap();
    int dt;
    clear_fp();
    run_tile(4, 11'h7FD, 11'h7FE, 1'b0, -1, -1, -1, dt);
    check_done_t("wrap", dt, 18);
  endtask
  task automatic test_random();
    int dt, len;
    for (int n = 0; n < 25; n++) begin
      clear_fp();
      for (int i = 0; i < 64; i++) fp[i] = ($urandom_range(0, 3) == 0);
      len = $urandom_range(0, 12);
      run_tile(len, addr_bw'($urandom), addr_bw'($urandom), 1'($urandom_range(0, 1)),
               -1, -1, -1, dt);
      checks++;
      if (dt < 0) begin
        errors++;
        $display("FAIL random tile %0d got no done exp one done", n);
      end
    end
  endtask
  initial begin
    bus.start = 1'b0;
    bus.exec_len = '0;
    bus.w_base = '0;
    bus.x_base = '0;
    bus.mode_cfg = 1'b0;
    bus.ofifo_full = 1'b0;
    clear_fp();
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_len();
    test_reset_mid();
    test_start_busy();
    test_back_to_back();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
